or1200_if_prefetch: RTL and testbench

OR1200_IF_PREFETCH -- requirements
Module: or1200_if_prefetch

---
 rtl/or1200_if_prefetch.sv | 253 +++++++++++++++++++++++++
 tb/tb_or1200_if_prefetch.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_if_prefetch.sv
// ----------------------------------------------------------------------------
// or1200_if_prefetch
//
// Instruction-fetch prefetch queue. The block issues one instruction-cache
// request at a time, keeps up to DEPTH completed responses in a circular
// queue, and presents the oldest entry to the CPU fetch stage. A PC redirect
// flushes the queue and restarts fetching at the new target. A response that
// was already in flight when the redirect arrived is thrown away. An IC
// error is queued as an error entry, and fetching then stops until the next
// redirect.
//
// Parameters
//   DEPTH     queue entries, power of two, 2..8
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous reset, active low
//   ic_adr_o       fetch address to IC (word aligned)
//   ic_cyc_o       fetch request valid; held with ic_adr_o until ack/err
//   ic_dat_i       IC response instruction
//   ic_ack_i       IC response done (ok)
//   ic_err_i       IC response done (error)
//   ic_tag_i       IC response tag
//   redir_i        PC redirect pulse (branch/exception/rfe)
//   redir_adr_i    redirect target
//   icpu_dat_o     head entry instruction
//   icpu_adr_o     head entry word address
//   icpu_tag_o     head entry tag
//   icpu_ack_o     head valid, ok
//   icpu_err_o     head valid, error
//   if_freeze      consumer stall; head popped when valid and not frozen
//
// Build option
//   OR1200_IF_PREFETCH_BYPASS_EN  when defined, a response arriving while the
//   queue is empty and the consumer is not frozen is forwarded to icpu_*
//   in the same cycle instead of being queued.
//
// state | meaning
// FETCH | may issue a request at fetch pc if a queue slot is free
// WAIT  | request outstanding, ic_adr_o held
// DRAIN | request outstanding but stale after redirect; response dropped
// HALT  | IC error seen; no requests until redirect
// ----------------------------------------------------------------------------
module or1200_if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ic_adr_o,
    output logic        ic_cyc_o,
    input  logic [31:0] ic_dat_i,
    input  logic        ic_ack_i,
    input  logic        ic_err_i,
    input  logic [3:0]  ic_tag_i,
    input  logic        redir_i,
    input  logic [31:0] redir_adr_i,
    output logic [31:0] icpu_dat_o,
    output logic [31:0] icpu_adr_o,
    output logic [3:0]  icpu_tag_o,
    output logic        icpu_ack_o,
    output logic        icpu_err_o,
    input  logic        if_freeze
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [5:0]  OR1200_OR32_NOP = 6'h05;
    localparam logic [31:0] ERR_INSN        = {OR1200_OR32_NOP, 26'h041_0000};

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [29:0]     pc_q, pc_d;
    logic [29:0]     req_q, req_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic [31:0]     mem_dat [DEPTH];
    logic [29:0]     mem_adr [DEPTH];
    logic [3:0]      mem_tag [DEPTH];
    logic            mem_err [DEPTH];

    logic            empty;
    logic            pop;
    logic            room;
    logic            resp;
    logic            issue;
    logic [29:0]     bus_adr;
    logic            accept;
    logic            bypass;
    logic            push;
    logic            flush;

    // Low address bits of the redirect target are ignored by design.
    logic unused_ok;
    assign unused_ok = ^redir_adr_i[1:0];

    assign empty = (count_q == '0);
    assign pop   = !empty && !if_freeze;
    // A slot freed by a same-cycle pop counts as room.
    assign room  = (count_q < CW'(DEPTH)) || pop;
    assign resp  = ic_ack_i || ic_err_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        issue   = 1'b0;
        bus_adr = pc_q;
        flush   = 1'b0;

        case (state_q)
            FETCH: begin
                issue   = room;
                bus_adr = pc_q;
            end
            WAIT, DRAIN: begin
                issue   = 1'b1;
                bus_adr = req_q;
            end
            default: begin
                issue   = 1'b0;
                bus_adr = pc_q;
            end
        endcase

        if (state_q == FETCH && issue) begin
            req_d = pc_q;
        end

        if (redir_i) begin
            flush   = 1'b1;
            pc_d    = redir_adr_i[31:2];
            // An unanswered request must still be waited out; its data is stale.
            state_d = (issue && !resp) ? DRAIN : FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (issue) begin
                        if (ic_err_i) begin
                            state_d = HALT;
                        end else if (ic_ack_i) begin
                            pc_d = pc_q + 30'd1;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (ic_err_i) begin
                        state_d = HALT;
                    end else if (ic_ack_i) begin
                        pc_d    = pc_q + 30'd1;
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    if (resp) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = HALT;
                end
            endcase
        end
    end

    assign accept = !redir_i && issue && resp && (state_q != DRAIN);

`ifdef OR1200_IF_PREFETCH_BYPASS_EN
    assign bypass = accept && empty && !if_freeze;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC[31:2];
            req_q   <= RESET_PC[31:2];
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_dat[wr_ptr_q] <= ic_err_i ? ERR_INSN : ic_dat_i;
            mem_adr[wr_ptr_q] <= bus_adr;
            mem_tag[wr_ptr_q] <= ic_tag_i;
            mem_err[wr_ptr_q] <= ic_err_i;
        end
    end

    // Request is masked while reset is asserted so the bus is quiet.
    assign ic_cyc_o = issue && rst;
    assign ic_adr_o = {bus_adr, 2'b00};

    always_comb begin
        icpu_dat_o = '0;
        icpu_adr_o = '0;
        icpu_tag_o = '0;
        icpu_ack_o = 1'b0;
        icpu_err_o = 1'b0;
        if (bypass) begin
            icpu_dat_o = ic_err_i ? ERR_INSN : ic_dat_i;
            icpu_adr_o = {bus_adr, 2'b00};
            icpu_tag_o = ic_tag_i;
            icpu_ack_o = !ic_err_i;
            icpu_err_o = ic_err_i;
        end else if (!empty) begin
            icpu_dat_o = mem_dat[rd_ptr_q];
            icpu_adr_o = {mem_adr[rd_ptr_q], 2'b00};
            icpu_tag_o = mem_tag[rd_ptr_q];
            icpu_ack_o = !mem_err[rd_ptr_q];
            icpu_err_o = mem_err[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_or1200_if_prefetch.sv
module tb_or1200_if_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] ERR_INSN = 32'h1441_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ic_adr_o;
    logic        ic_cyc_o;
    logic [31:0] ic_dat_i = '0;
    logic        ic_ack_i = 1'b0;
    logic        ic_err_i = 1'b0;
    logic [3:0]  ic_tag_i = '0;
    logic        redir_i = 1'b0;
    logic [31:0] redir_adr_i = '0;
    logic [31:0] icpu_dat_o;
    logic [31:0] icpu_adr_o;
    logic [3:0]  icpu_tag_o;
    logic        icpu_ack_o;
    logic        icpu_err_o;
    logic        if_freeze = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    or1200_if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .ic_adr_o(ic_adr_o), .ic_cyc_o(ic_cyc_o),
        .ic_dat_i(ic_dat_i), .ic_ack_i(ic_ack_i), .ic_err_i(ic_err_i), .ic_tag_i(ic_tag_i),
        .redir_i(redir_i), .redir_adr_i(redir_adr_i),
        .icpu_dat_o(icpu_dat_o), .icpu_adr_o(icpu_adr_o), .icpu_tag_o(icpu_tag_o),
        .icpu_ack_o(icpu_ack_o), .icpu_err_o(icpu_err_o),
        .if_freeze(if_freeze)
    );

    typedef struct {
        logic [31:0] dat;
        logic [31:0] adr;
        logic [3:0]  tag;
        logic        err;
    } entry_t;

    task automatic drive(input logic ack, input logic err, input logic [31:0] dat,
                         input logic [3:0] tag, input logic frz, input logic rd,
                         input logic [31:0] radr);
        ic_ack_i = ack; ic_err_i = err; ic_dat_i = dat; ic_tag_i = tag;
        if_freeze = frz; redir_i = rd; redir_adr_i = radr;
    endtask

    // Leaves the bench at a negedge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (ic_cyc_o !== 1'b0 || icpu_ack_o !== 1'b0 || icpu_err_o !== 1'b0 ||
            icpu_dat_o !== 32'h0 || icpu_adr_o !== 32'h0 || icpu_tag_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: cyc=%b ack=%b err=%b dat=%h adr=%h tag=%h, required all zero",
                     ic_cyc_o, icpu_ack_o, icpu_err_o, icpu_dat_o, icpu_adr_o, icpu_tag_o);
        end
        checks++;
        if (ic_adr_o !== RESET_PC) begin
            errors++;
            $display("FAIL reset_adr: got %h required %h", ic_adr_o, RESET_PC);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ic_cyc_o !== 1'b1 || ic_adr_o !== RESET_PC) begin
            errors++;
            $display("FAIL reset_release: cyc=%b adr=%h required cyc=1 adr=%h", ic_cyc_o, ic_adr_o, RESET_PC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 32'hA000_0000 + k, 4'(k), 0, 0, 0);
            #1;
            checks++;
            if (ic_cyc_o !== 1'b1 || ic_adr_o !== 32'h100 + 32'(4 * k)) begin
                errors++;
                $display("FAIL stream_adr[%0d]: cyc=%b adr=%h required cyc=1 adr=%h",
                         k, ic_cyc_o, ic_adr_o, 32'h100 + 32'(4 * k));
            end
`ifdef OR1200_IF_PREFETCH_BYPASS_EN
            checks++;
            if (icpu_ack_o !== 1'b1 || icpu_adr_o !== 32'h100 + 32'(4 * k) ||
                icpu_dat_o !== 32'hA000_0000 + k) begin
                errors++;
                $display("FAIL stream_head[%0d]: ack=%b adr=%h dat=%h", k, icpu_ack_o, icpu_adr_o, icpu_dat_o);
            end
`else
            if (k == 0) begin
                checks++;
                if (icpu_ack_o !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_first_latency: ack=%b required 0", icpu_ack_o);
                end
            end else begin
                checks++;
                if (icpu_ack_o !== 1'b1 || icpu_adr_o !== 32'h100 + 32'(4 * (k - 1)) ||
                    icpu_dat_o !== 32'hA000_0000 + (k - 1) || icpu_tag_o !== 4'(k - 1)) begin
                    errors++;
                    $display("FAIL stream_head[%0d]: ack=%b adr=%h dat=%h tag=%h", k,
                             icpu_ack_o, icpu_adr_o, icpu_dat_o, icpu_tag_o);
                end
            end
`endif
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_full();
        int acked;
        acked = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            #1;
            if (ic_cyc_o === 1'b1) begin
                ic_ack_i = 1'b1;
                ic_dat_i = 32'hB000_0000 + acked;
                acked++;
            end
            if (k >= 5) begin
                checks++;
                if (ic_cyc_o !== 1'b0 || icpu_adr_o !== 32'h100 || icpu_ack_o !== 1'b1) begin
                    errors++;
                    $display("FAIL full_stall[%0d]: cyc=%b head_adr=%h ack=%b required cyc=0 adr=100 ack=1",
                             k, ic_cyc_o, icpu_adr_o, icpu_ack_o);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (acked != DEPTH) begin
            errors++;
            $display("FAIL full_count: accepted %0d required %0d", acked, DEPTH);
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            #1;
            if (k < 4) begin
                checks++;
                if (icpu_ack_o !== 1'b1 || icpu_adr_o !== 32'h100 + 32'(4 * k) ||
                    icpu_dat_o !== 32'hB000_0000 + k) begin
                    errors++;
                    $display("FAIL full_drain[%0d]: ack=%b adr=%h dat=%h", k, icpu_ack_o, icpu_adr_o, icpu_dat_o);
                end
            end else begin
                checks++;
                if (icpu_ack_o !== 1'b0) begin
                    errors++;
                    $display("FAIL full_empty: ack=%b required 0", icpu_ack_o);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1, 0, 32'h1111_1111, 4'h1, 1, 0, 0);          // queue 0x100
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0);                          // issue 0x104
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 1, 32'h0000_2003);              // redirect, still waiting
        @(negedge clk);
        drive(1, 0, 32'hDEAD_BEEF, 4'h7, 1, 0, 0);           // stale ack
        #1;
        checks++;
        if (icpu_ack_o !== 1'b0 || icpu_err_o !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush: ack=%b err=%b required 0", icpu_ack_o, icpu_err_o);
        end
        checks++;
        if (ic_cyc_o !== 1'b1 || ic_adr_o !== 32'h104) begin
            errors++;
            $display("FAIL redir_hold: cyc=%b adr=%h required cyc=1 adr=104", ic_cyc_o, ic_adr_o);
        end
        @(negedge clk);
        drive(1, 0, 32'h2222_2222, 4'h2, 1, 0, 0);
        #1;
        checks++;
        if (ic_cyc_o !== 1'b1 || ic_adr_o !== 32'h2000 || icpu_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL redir_target: cyc=%b adr=%h head_ack=%b required cyc=1 adr=2000 ack=0",
                     ic_cyc_o, ic_adr_o, icpu_ack_o);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0);
        #1;
        checks++;
        if (icpu_ack_o !== 1'b1 || icpu_adr_o !== 32'h2000 || icpu_dat_o !== 32'h2222_2222) begin
            errors++;
            $display("FAIL redir_first: ack=%b adr=%h dat=%h required 1/2000/22222222",
                     icpu_ack_o, icpu_adr_o, icpu_dat_o);
        end
    endtask

    task automatic test_error();
        do_reset();
        drive(0, 0, 0, 0, 1, 1, 32'h0000_0200);
        @(negedge clk);
        drive(1, 0, 32'hDEAD_0000, 4'h3, 1, 0, 0);           // stale response
        @(negedge clk);
        drive(0, 1, 32'h5555_5555, 4'hd, 1, 0, 0);
        #1;
        checks++;
        if (ic_cyc_o !== 1'b1 || ic_adr_o !== 32'h200) begin
            errors++;
            $display("FAIL err_issue: cyc=%b adr=%h required cyc=1 adr=200", ic_cyc_o, ic_adr_o);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 1, 0, 0);
            #1;
            checks++;
            if (icpu_err_o !== 1'b1 || icpu_ack_o !== 1'b0 || icpu_tag_o !== 4'hd ||
                icpu_adr_o !== 32'h200 || icpu_dat_o !== ERR_INSN || ic_cyc_o !== 1'b0) begin
                errors++;
                $display("FAIL err_head[%0d]: err=%b ack=%b tag=%h adr=%h dat=%h cyc=%b", k,
                         icpu_err_o, icpu_ack_o, icpu_tag_o, icpu_adr_o, icpu_dat_o, ic_cyc_o);
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);                          // pop error entry
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (icpu_err_o !== 1'b0 || ic_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL err_halt: err=%b cyc=%b required 0/0", icpu_err_o, ic_cyc_o);
        end
        drive(0, 0, 0, 0, 0, 1, 32'h0000_0300);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (ic_cyc_o !== 1'b1 || ic_adr_o !== 32'h300) begin
            errors++;
            $display("FAIL err_resume: cyc=%b adr=%h required cyc=1 adr=300", ic_cyc_o, ic_adr_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(1, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        drive(1, 0, 32'h3333_3333, 4'h4, 1, 0, 0);
        #1;
        checks++;
        if (ic_cyc_o !== 1'b1 || ic_adr_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_top: cyc=%b adr=%h required cyc=1 adr=fffffffc", ic_cyc_o, ic_adr_o);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0);
        #1;
        checks++;
        if (ic_cyc_o !== 1'b1 || ic_adr_o !== 32'h0 || icpu_err_o !== 1'b0 ||
            icpu_adr_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_next: cyc=%b adr=%h err=%b head_adr=%h", ic_cyc_o, ic_adr_o, icpu_err_o, icpu_adr_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 32'hC000_0000 + k, 4'h5, 1, 0, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 1, 0, 0);                          // issue 0x10C, left waiting
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ic_cyc_o !== 1'b0 || ic_adr_o !== RESET_PC || icpu_ack_o !== 1'b0 || icpu_err_o !== 1'b0 ||
            icpu_dat_o !== 32'h0 || icpu_adr_o !== 32'h0 || icpu_tag_o !== 4'h0) begin
            errors++;
            $display("FAIL midreset_outputs: cyc=%b adr=%h ack=%b err=%b dat=%h hadr=%h tag=%h",
                     ic_cyc_o, ic_adr_o, icpu_ack_o, icpu_err_o, icpu_dat_o, icpu_adr_o, icpu_tag_o);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ic_cyc_o !== 1'b1 || ic_adr_o !== RESET_PC || icpu_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart: cyc=%b adr=%h ack=%b", ic_cyc_o, ic_adr_o, icpu_ack_o);
        end
    endtask

    task automatic test_random();
        entry_t      q[$];
        entry_t      e;
        logic [31:0] pc, req_adr, cur_adr, radr;
        logic        pending, draining, halted;
        logic        frz, rd, ack, err, exp_cyc, byp, pop;
        logic [31:0] exp_dat, exp_adr;
        logic [3:0]  exp_tag;
        logic        exp_ack, exp_err;
        do_reset();
        pc = RESET_PC; req_adr = RESET_PC;
        pending = 0; draining = 0; halted = 0;
        for (int n = 0; n < 3000; n++) begin
            frz  = ($urandom_range(0, 9) < 4);
            rd   = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            radr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
            drive(0, 0, 0, 0, frz, rd, radr);
            #1;
            exp_cyc = !halted && (pending || q.size() < DEPTH || (q.size() > 0 && !frz));
            cur_adr = pending ? req_adr : pc;
            checks++;
            if (ic_cyc_o !== exp_cyc || (exp_cyc && ic_adr_o !== cur_adr)) begin
                errors++;
                $display("FAIL rand_req[%0d]: cyc=%b adr=%h required cyc=%b adr=%h",
                         n, ic_cyc_o, ic_adr_o, exp_cyc, cur_adr);
            end
            ack = 0; err = 0;
            if (exp_cyc) begin
                ack = ($urandom_range(0, 1) == 1);
                err = !ack && ($urandom_range(0, 39) == 0);
            end
            ic_ack_i = ack; ic_err_i = err;
            ic_dat_i = $urandom; ic_tag_i = 4'($urandom_range(0, 15));
            #1;
            byp = 0;
`ifdef OR1200_IF_PREFETCH_BYPASS_EN
            byp = (ack || err) && q.size() == 0 && !frz && !rd && !draining;
`endif
            exp_dat = 0; exp_adr = 0; exp_tag = 0; exp_ack = 0; exp_err = 0;
            if (byp) begin
                exp_dat = err ? ERR_INSN : ic_dat_i; exp_adr = cur_adr; exp_tag = ic_tag_i;
                exp_ack = ack; exp_err = err;
            end else if (q.size() > 0) begin
                exp_dat = q[0].dat; exp_adr = q[0].adr; exp_tag = q[0].tag;
                exp_ack = !q[0].err; exp_err = q[0].err;
            end
            checks++;
            if (icpu_ack_o !== exp_ack || icpu_err_o !== exp_err || icpu_dat_o !== exp_dat ||
                icpu_adr_o !== exp_adr || icpu_tag_o !== exp_tag) begin
                errors++;
                $display("FAIL rand_head[%0d]: ack=%b err=%b dat=%h adr=%h tag=%h required %b %b %h %h %h",
                         n, icpu_ack_o, icpu_err_o, icpu_dat_o, icpu_adr_o, icpu_tag_o,
                         exp_ack, exp_err, exp_dat, exp_adr, exp_tag);
            end
            pop = (q.size() > 0) && !frz;
            if (rd) begin
                q.delete();
                if (exp_cyc && !pending) req_adr = pc;
                draining = exp_cyc && !(ack || err);
                pending  = draining;
                pc       = {radr[31:2], 2'b00};
                halted   = 0;
            end else begin
                if (pop) void'(q.pop_front());
                if (exp_cyc) begin
                    if (!pending) req_adr = pc;
                    if (ack || err) begin
                        if (draining) begin
                            draining = 0;
                        end else begin
                            if (!byp) begin
                                e.dat = err ? ERR_INSN : ic_dat_i;
                                e.adr = cur_adr; e.tag = ic_tag_i; e.err = err;
                                q.push_back(e);
                            end
                            if (err) halted = 1;
                            else     pc = pc + 32'd4;
                        end
                        pending = 0;
                    end else begin
                        pending = 1;
                    end
                end
            end
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_error();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
